// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: runtime prescaler, 5..9 data bits, optional
// even/odd parity, 2-flop RXD synchroniser and 3-sample majority voting.
module uart_rx_os #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RXD,
    input  logic                      PARITY_EN,
    input  logic                      PARITY_TYPE,
    input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
    output logic [DATA_WIDTH-1:0]     RXDATA,
    output logic                      VALID_RX,
    output logic                      PARITY_ERROR,
    output logic                      STOP_ERROR,
    output logic                      BUSY
);

    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam logic [PRESCALE_WIDTH-1:0] P_ONE = PRESCALE_WIDTH'(1);
    localparam logic [PRESCALE_WIDTH-1:0] P_MIN = PRESCALE_WIDTH'(4);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                    state_reg, state_next;
    logic                      rx_meta_reg, rxs_reg;
    logic [PRESCALE_WIDTH-1:0] cnt_reg, cnt_next;
    logic [PRESCALE_WIDTH-1:0] p_reg, p_next;
    logic                      pen_reg, pen_next;
    logic                      ptype_reg, ptype_next;
    logic [1:0]                samp_reg, samp_next;
    logic [BIT_W-1:0]          bit_idx_reg, bit_idx_next;
    logic [DATA_WIDTH-1:0]     shift_reg, shift_next;
    logic                      perr_reg, perr_next;
    logic [DATA_WIDTH-1:0]     rxdata_reg, rxdata_next;
    logic                      valid_reg, valid_next;
    logic                      perr_out_reg, perr_out_next;
    logic                      serr_out_reg, serr_out_next;

    logic [PRESCALE_WIDTH-1:0] half;
    logic                      wrap, decide, majority;

    assign half     = p_reg >> 1;
    assign wrap     = (cnt_reg == p_reg - P_ONE);
    assign decide   = (cnt_reg == half + P_ONE);
    // Third vote is the live sample taken in the decision cycle itself.
    assign majority = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & rxs_reg) |
                      (samp_reg[1] & rxs_reg);

    always_comb begin
        state_next    = state_reg;
        cnt_next      = wrap ? '0 : cnt_reg + P_ONE;
        p_next        = p_reg;
        pen_next      = pen_reg;
        ptype_next    = ptype_reg;
        samp_next     = samp_reg;
        bit_idx_next  = bit_idx_reg;
        shift_next    = shift_reg;
        perr_next     = perr_reg;
        rxdata_next   = rxdata_reg;
        valid_next    = 1'b0;
        perr_out_next = 1'b0;
        serr_out_next = 1'b0;

        if (cnt_reg == half - P_ONE) samp_next[0] = rxs_reg;
        if (cnt_reg == half)         samp_next[1] = rxs_reg;

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (!rxs_reg) begin
                    // The detection cycle itself is count 0 of the start bit.
                    state_next = START;
                    cnt_next   = P_ONE;
                    p_next     = (PRESCALE < P_MIN) ? P_MIN : PRESCALE;
                    pen_next   = PARITY_EN;
                    ptype_next = PARITY_TYPE;
                    perr_next  = 1'b0;
                end
            end
            START: begin
                if (decide && majority) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (wrap) begin
                    state_next   = DATA;
                    bit_idx_next = '0;
                end
            end
            DATA: begin
                if (decide) shift_next = {majority, shift_reg[DATA_WIDTH-1:1]};
                if (wrap) begin
                    if (bit_idx_reg == BIT_W'(DATA_WIDTH - 1))
                        state_next = pen_reg ? PARITY : STOP;
                    else
                        bit_idx_next = bit_idx_reg + BIT_W'(1);
                end
            end
            PARITY: begin
                if (decide) perr_next = (majority != ((^shift_reg) ^ ptype_reg));
                if (wrap) state_next = STOP;
            end
            STOP: begin
                if (decide) begin
                    state_next    = IDLE;
                    cnt_next      = '0;
                    rxdata_next   = shift_reg;
                    serr_out_next = ~majority;
                    perr_out_next = perr_reg;
                    valid_next    = majority & ~perr_reg;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            rx_meta_reg  <= 1'b1;
            rxs_reg      <= 1'b1;
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            p_reg        <= P_MIN;
            pen_reg      <= 1'b0;
            ptype_reg    <= 1'b0;
            samp_reg     <= 2'b11;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            perr_reg     <= 1'b0;
            rxdata_reg   <= '0;
            valid_reg    <= 1'b0;
            perr_out_reg <= 1'b0;
            serr_out_reg <= 1'b0;
        end else begin
            rx_meta_reg  <= RXD;
            rxs_reg      <= rx_meta_reg;
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            p_reg        <= p_next;
            pen_reg      <= pen_next;
            ptype_reg    <= ptype_next;
            samp_reg     <= samp_next;
            bit_idx_reg  <= bit_idx_next;
            shift_reg    <= shift_next;
            perr_reg     <= perr_next;
            rxdata_reg   <= rxdata_next;
            valid_reg    <= valid_next;
            perr_out_reg <= perr_out_next;
            serr_out_reg <= serr_out_next;
        end
    end

    // A start seen in the end-of-frame cycle must not raise BUSY alongside the flags.
    assign BUSY         = (state_reg != IDLE) |
                          (~rxs_reg & ~(valid_reg | perr_out_reg | serr_out_reg));
    assign RXDATA       = rxdata_reg;
    assign VALID_RX     = valid_reg;
    assign PARITY_ERROR = perr_out_reg;
    assign STOP_ERROR   = serr_out_reg;

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: an 8-bit instance (P=8) and a 7-bit
// instance (P=16, no parity) share clock and reset.
module tb_uart_rx_os;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       rxd8, pen8, pt8, rxd7, pen7, pt7;
    logic [5:0] pres8, pres7;
    logic [7:0] rxdata8;
    logic [6:0] rxdata7;
    logic       v8, pe8, se8, busy8, v7, pe7, se7, busy7;

    uart_rx_os #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut8 (
        .CLK(clk), .RST(rst_n), .RXD(rxd8), .PARITY_EN(pen8), .PARITY_TYPE(pt8),
        .PRESCALE(pres8), .RXDATA(rxdata8), .VALID_RX(v8), .PARITY_ERROR(pe8),
        .STOP_ERROR(se8), .BUSY(busy8)
    );

    uart_rx_os #(.DATA_WIDTH(7), .PRESCALE_WIDTH(6)) dut7 (
        .CLK(clk), .RST(rst_n), .RXD(rxd7), .PARITY_EN(pen7), .PARITY_TYPE(pt7),
        .PRESCALE(pres7), .RXDATA(rxdata7), .VALID_RX(v7), .PARITY_ERROR(pe7),
        .STOP_ERROR(se7), .BUSY(busy7)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [8:0] data;
        logic       v, pe, se;
        int         cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q7[$];
    int   busy_run8  = 0;
    int   last_busy8 = 0;

    always @(posedge clk) begin : mon8
        exp_t e;
        #1;
        if (v8 | pe8 | se8) begin
            $display("[TB] dut8 frame data=%02h valid=%0b perr=%0b serr=%0b cyc=%0d",
                     rxdata8, v8, pe8, se8, cyc);
            check("dut8_pulse_expected", (q8.size() != 0), 1);
            if (q8.size() != 0) begin
                e = q8.pop_front();
                check("dut8_rxdata", rxdata8, e.data);
                check("dut8_valid", v8, e.v);
                check("dut8_parity_err", pe8, e.pe);
                check("dut8_stop_err", se8, e.se);
                check("dut8_pulse_cycle", cyc, e.cyc);
            end
        end
        if (busy8) busy_run8++;
        else if (busy_run8 != 0) begin
            last_busy8 = busy_run8;
            busy_run8  = 0;
        end
    end

    always @(posedge clk) begin : mon7
        exp_t e;
        #1;
        if (v7 | pe7 | se7) begin
            $display("[TB] dut7 frame data=%02h valid=%0b perr=%0b serr=%0b cyc=%0d",
                     rxdata7, v7, pe7, se7, cyc);
            check("dut7_pulse_expected", (q7.size() != 0), 1);
            if (q7.size() != 0) begin
                e = q7.pop_front();
                check("dut7_rxdata", rxdata7, e.data);
                check("dut7_valid", v7, e.v);
                check("dut7_parity_err", pe7, e.pe);
                check("dut7_stop_err", se7, e.se);
                check("dut7_pulse_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic drive(input int inst, input logic val);
        if (inst == 0) rxd8 = val;
        else           rxd7 = val;
    endtask

    // Drives one frame bit-by-bit on the pin; pin bit offset j lands on rxs count j.
    task automatic send(input int inst, input logic [8:0] d, input bit par_flip,
                        input bit stop_bit, input bit glitch, input bit scramble,
                        input int abort_bit, input int gap);
        int   dw, p, h, nb, k;
        bit   pen, pt, saved_pt;
        logic par;
        logic bitv [12];
        logic [5:0] saved_p;
        exp_t e;
        dw  = (inst == 0) ? 8 : 7;
        p   = (inst == 0) ? int'(pres8) : int'(pres7);
        pen = (inst == 0) ? pen8 : pen7;
        pt  = (inst == 0) ? pt8 : pt7;
        h   = p / 2;
        par = pt ^ par_flip;
        for (int i = 0; i < dw; i++) par ^= d[i];
        bitv[0] = 1'b0;
        for (int i = 0; i < dw; i++) bitv[1 + i] = d[i];
        if (pen) bitv[1 + dw] = par;
        nb = 2 + dw + (pen ? 1 : 0);
        bitv[nb - 1] = stop_bit;
        saved_p  = pres8;
        saved_pt = pt8;
        k = 0;
        for (int b = 0; b < nb; b++) begin
            if (b == abort_bit) break;
            for (int j = 0; j < p; j++) begin
                @(negedge clk);
                if (b == 0 && j == 0) begin
                    k = cyc;
                    if (abort_bit < 0) begin
                        e.data = d & ((9'd1 << dw) - 9'd1);
                        e.pe   = pen & par_flip;
                        e.se   = ~stop_bit;
                        e.v    = ~e.pe & ~e.se;
                        e.cyc  = k + 2 + (nb - 1) * p + h + 2;
                        if (inst == 0) q8.push_back(e);
                        else           q7.push_back(e);
                    end
                end
                if (scramble && b == 2 && j == 0) begin
                    pres8 = 6'd5;
                    pt8   = ~pt8;
                end
                drive(inst, bitv[b] ^ (glitch && b >= 1 && b <= dw && j == h));
            end
        end
        if (scramble) begin
            pres8 = saved_p;
            pt8   = saved_pt;
        end
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            drive(inst, 1'b1);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rxdata8"}, rxdata8, 0);
        check({tag, "_flags8"}, {v8, pe8, se8, busy8}, 0);
        check({tag, "_rxdata7"}, rxdata7, 0);
        check({tag, "_flags7"}, {v7, pe7, se7, busy7}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        rxd8 = 1'b1; pen8 = 1'b1; pt8 = 1'b0; pres8 = 6'd8;
        rxd7 = 1'b1; pen7 = 1'b0; pt7 = 1'b0; pres7 = 6'd16;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        check_idle_outputs("post_reset");

        // Even parity, good frame
        send(0, 9'h6F, 0, 1, 0, 0, -1, 16);
        check("busy_len_frame", last_busy8, 10 * 8 + 4 + 2);

        // Odd parity: good, parity error, parity + stop error
        pt8 = 1'b1;
        send(0, 9'hCC, 0, 1, 0, 0, -1, 16);
        send(0, 9'hCC, 1, 1, 0, 0, -1, 16);
        send(0, 9'hCC, 1, 0, 0, 0, -1, 16);

        // False start: two low cycles in IDLE
        @(negedge clk); rxd8 = 1'b0;
        @(negedge clk); rxd8 = 1'b0;
        @(negedge clk); rxd8 = 1'b1;
        repeat (24) @(negedge clk);
        check("busy_len_false_start", last_busy8, 4 + 2);
        check("rxdata_after_false_start", rxdata8, 8'hCC);

        // Good frame with config disturbed mid-frame
        pt8 = 1'b0;
        send(0, 9'h3D, 0, 1, 0, 1, -1, 16);

        // Glitch at the centre sample of every data bit
        send(0, 9'hA5, 0, 1, 1, 0, -1, 16);

        // Reset in the middle of the data bits
        send(0, 9'h55, 0, 1, 0, 0, 4, 0);
        @(negedge clk);
        rst_n = 1'b0;
        rxd8  = 1'b1;
        @(posedge clk); #1;
        check("midreset_rxdata8", rxdata8, 0);
        check("midreset_flags8", {v8, pe8, se8, busy8}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        send(0, 9'h13, 0, 1, 0, 0, -1, 16);

        // 7-bit, P=16, no parity, back-to-back frames
        send(1, 9'h2A, 0, 1, 0, 0, -1, 0);
        send(1, 9'h7F, 0, 1, 0, 0, -1, 32);

        repeat (20) @(negedge clk);
        check("dut8_queue_drained", q8.size(), 0);
        check("dut7_queue_drained", q7.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Parametrised, oversampling UART receiver: the next generation of the team's fixed-width, one-bit-per-clock receiver. It adds a runtime baud prescaler, configurable data width, and selectable even/odd parity. It also adds 2-flop input synchronisation, 3-sample majority voting, and false-start rejection. It sits between the RXD pad and the byte-consuming logic (FIFO/register bank), all in the single system clock domain.

## Interface
- DATA_WIDTH, 8, data bits per frame; legal 5..9
- PRESCALE_WIDTH, 6, width of PRESCALE input
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  synchronous, active-low reset
- RXD  in  1  serial line, idle high, asynchronous to CLK
- PARITY_EN  in  1  1 = frame carries parity bit after data
- PARITY_TYPE  in  1  0 = even, 1 = odd
- PRESCALE  in  PRESCALE_WIDTH  CLK cycles per bit; values <4 treated as 4
- RXDATA  out  DATA_WIDTH  last received data, LSB first on line; reset 0
- VALID_RX  out  1  1-cycle pulse, good frame; reset 0
- PARITY_ERROR  out  1  1-cycle pulse, parity mismatch; reset 0
- STOP_ERROR  out  1  1-cycle pulse, stop bit sampled 0; reset 0
- BUSY  out  1  high while a frame is in progress; reset 0

## Operation
- RXD passes through 2-flop synchroniser (reset value 1); all logic uses synchronised value `rxs`.
- PRESCALE (clamped), PARITY_EN, and PARITY_TYPE are latched on the IDLE->START transition. Changes mid-frame have no effect.
- H = P>>1, where P is the latched prescale. Bit counter `cnt` runs 0..P-1 and wraps.
- Each bit is sampled at cnt H-1, H, H+1. Bit value = majority of the 3 samples, decided at cnt H+1.
- FSM states:
  - IDLE: BUSY=0. `rxs`==0 -> START, cnt=0.
  - START: at decision, majority 1 -> IDLE (false start, no outputs). Otherwise continue; at cnt wrap -> DATA, bit index 0.
  - DATA: shifts DATA_WIDTH bits LSB first. After the last bit's wrap -> PARITY if PARITY_EN, else STOP.
  - PARITY: at decision, compares the received bit with the expected bit. Expected = XOR(data) ^ PARITY_TYPE. Mismatch is flagged internally. At wrap -> STOP.
  - STOP: at decision, frame ends; FSM -> IDLE on the next cycle without waiting for end of stop bit.
- End-of-frame, cycle after STOP decision:
  - RXDATA is loaded with the received data (updated even on error).
  - Exactly one of the following is true:
    - VALID_RX=1 (no errors), or
    - PARITY_ERROR and/or STOP_ERROR=1 (both may pulse together).
  - All three flags are 0 on every other cycle.
- Reset asserted at any cycle, including mid-frame:
  - next edge: FSM IDLE, counters 0, synchroniser 1, all outputs 0.
  - no partial frame is reported.

## Timing
- Pin-to-`rxs` latency: 2 cycles.
- Let T0 = first cycle with `rxs`==0 in IDLE, and N = DATA_WIDTH + 1 + PARITY_EN (bits before stop).
  - STOP decision at T0 + N·P + H + 1.
  - Output pulses at T0 + N·P + H + 2.
- BUSY: high T0..STOP decision cycle inclusive. Low in the output-pulse cycle.
- A new start edge is detectable from the output-pulse cycle onward, so back-to-back frames with a 1-bit stop are received without loss.
- False start: BUSY high T0..T0+H+1, then low. No flag pulses.
- A single-cycle glitch on `rxs` at any one of the 3 sample points does not change the decided bit.
- No backpressure: a consumer must capture RXDATA on VALID_RX. RXDATA holds until the next end-of-frame.

## Test plan
- P=8, DATA_WIDTH=8, even parity; send start, 0x6F, parity 0, stop 1 -> one VALID_RX pulse, RXDATA=0x6F, both error flags 0 throughout.
- Odd parity, 0xCC:
  - parity bit 1 -> VALID_RX.
  - parity bit 0 -> PARITY_ERROR pulse, VALID_RX 0, RXDATA=0xCC.
  - parity 0 and stop 0 -> PARITY_ERROR and STOP_ERROR in the same cycle.
- RXD low for 2 cycles then high, in IDLE -> BUSY pulses for H+2 cycles, no flag pulses, RXDATA unchanged. Then a valid frame 0x3D -> VALID_RX, RXDATA=0x3D.
- Single-cycle inverted glitch at cnt H of every data bit of 0xA5 -> RXDATA=0xA5, VALID_RX.
- Reset asserted mid-DATA of frame 0x55 -> all outputs 0 next cycle, no pulse for that frame. A following frame 0x13 -> RXDATA=0x13, VALID_RX.
- DATA_WIDTH=7, P=16, parity disabled; two back-to-back frames 0x2A, 0x7F with a 1-bit stop -> two VALID_RX pulses, each at T0 + 8·16 + 10, with RXDATA=0x2A then 0x7F.
